// File: rtl/rr_mux_arb_4.sv
`default_nettype none
// ============================================================================
// Module      : rr_mux_arb_4
// Description : Four-requester round-robin arbiter with a one-entry
//               registered output slot (y / y_valid / y_src).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_mux_arb_4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [3:0]   gnt,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [1:0]   y_src
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Last-grant pointer starts at 3 so requester 0 is searched first.
    localparam logic [1:0] c_ptr_init = 2'd3;

    state_t         r_state;
    state_t         w_state_next;
    logic [1:0]     r_ptr;
    logic [W-1:0]   r_y;
    logic [1:0]     r_src;

    logic           w_load;
    logic           w_found;
    logic [1:0]     w_winner;
    logic [1:0]     w_idx;
    logic [W-1:0]   w_d_sel;

    assign y_valid = (r_state == FULL);
    assign y       = r_y;
    assign y_src   = r_src;

    // Gating with rst_n keeps gnt quiet while reset is held.
    assign w_load = rst_n & (|req) & (~y_valid | y_ready);

    always_comb begin
        w_found  = 1'b0;
        w_winner = r_ptr;
        w_idx    = r_ptr;
        for (int k = 1; k <= 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        gnt = 4'b0000;
        if (w_load) begin
            gnt[w_winner] = 1'b1;
        end
    end

    always_comb begin
        w_d_sel = d0;
        case (w_winner)
            2'd0:    w_d_sel = d0;
            2'd1:    w_d_sel = d1;
            2'd2:    w_d_sel = d2;
            default: w_d_sel = d3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (w_load) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (w_load) begin
                    w_state_next = FULL;
                end else if (y_ready) begin
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y   <= '0;
            r_src <= 2'd0;
            r_ptr <= c_ptr_init;
        end else if (w_load) begin
            r_y   <= w_d_sel;
            r_src <= w_winner;
            r_ptr <= w_winner;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arb_4.sv
`default_nettype none
// Testbench for rr_mux_arb_4: directed scenarios plus randomized traffic,
// checked against a queue-based scoreboard and a round-robin reference model.
module tb_rr_mux_arb_4;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [W-1:0] d0 = '0;
    logic [W-1:0] d1 = '0;
    logic [W-1:0] d2 = '0;
    logic [W-1:0] d3 = '0;
    logic         y_ready = 1'b0;
    logic [3:0]   gnt;
    logic [W-1:0] y;
    logic         y_valid;
    logic [1:0]   y_src;

    rr_mux_arb_4 #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .d0      (d0),
        .d1      (d1),
        .d2      (d2),
        .d3      (d3),
        .gnt     (gnt),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_src   (y_src)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [W+1:0] exp_q[$];

    // Reference model state
    int           m_ptr = 3;
    bit           m_valid = 1'b0;
    logic [W-1:0] m_y = '0;
    logic [1:0]   m_src = 2'd0;
    bit           last_load = 1'b0;
    int           last_win = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, check at +1, advance the model.
    task automatic cycle(input logic [3:0] r, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] e, input bit rdy);
        logic [3:0]   eg;
        logic [W-1:0] dv[4];
        bit           load;
        int           win;
        @(negedge clk);
        rst_n   = 1'b1;
        req     = r;
        d0      = a;
        d1      = b;
        d2      = c;
        d3      = e;
        y_ready = rdy;
        #1;
        chk("y_valid", y_valid, m_valid);
        if (m_valid) begin
            chk("y_held", y, m_y);
            chk("y_src_held", y_src, m_src);
        end
        load = (r != 4'b0000) && (!m_valid || rdy);
        win  = -1;
        if (load) begin
            for (int k = 1; k <= 4; k++) begin
                int i;
                i = (m_ptr + k) % 4;
                if (win < 0 && r[i]) win = i;
            end
        end
        eg = load ? 4'(1 << win) : 4'b0000;
        chk("gnt", gnt, eg);
        if (load) begin
            dv = '{a, b, c, e};
            exp_q.push_back({2'(win), dv[win]});
            m_valid = 1'b1;
            m_ptr   = win;
            m_y     = dv[win];
            m_src   = 2'(win);
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        last_load = load;
        last_win  = win;
    endtask

    // Scoreboard monitor: pops one expected item per accepted handshake.
    initial begin
        logic [W+1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && y_valid === 1'b1 && y_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_unexpected: got y=%0h src=%0d expected no item", y, y_src);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_y", y, e[W-1:0]);
                    chk("sb_src", y_src, e[W+1:W]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]   rr_seq[5];
        bit           pend[4];
        logic [W-1:0] pdat[4];
        int           waitc[4];
        logic [3:0]   r;

        // Reset state with all requests high: gnt must stay low.
        req     = 4'b1111;
        y_ready = 1'b1;
        #2;
        chk("rst_y_valid", y_valid, 1'b0);
        chk("rst_y", y, '0);
        chk("rst_y_src", y_src, 2'd0);
        chk("rst_gnt", gnt, 4'b0000);

        // Idle after reset
        for (int n = 0; n < 10; n++) begin
            cycle(4'b0000, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
            chk("idle_gnt", gnt, 4'b0000);
            chk("idle_valid", y_valid, 1'b0);
        end

        // Full rotation with all requesters active
        rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int n = 0; n < 5; n++) begin
            cycle(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1);
            chk("rr_seq_gnt", gnt, rr_seq[n]);
        end
        cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Rotation from ptr=1
        cycle(4'b0010, 4'd0, 4'd5, 4'd0, 4'd0, 1'b1);
        chk("rot_setup_gnt", gnt, 4'b0010);
        cycle(4'b0011, 4'd6, 4'd5, 4'd0, 4'd0, 1'b1);
        chk("rot_gnt0", gnt, 4'b0001);
        cycle(4'b0010, 4'd0, 4'd5, 4'd0, 4'd0, 1'b1);
        chk("rot_gnt1", gnt, 4'b0010);
        cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Backpressure
        cycle(4'b0100, 4'd0, 4'd0, 4'd7, 4'd0, 1'b0);
        chk("bp_gnt", gnt, 4'b0100);
        for (int n = 0; n < 5; n++) begin
            cycle(4'b1111, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
            chk("bp_hold_gnt", gnt, 4'b0000);
            chk("bp_hold_y", y, 4'd7);
            chk("bp_hold_src", y_src, 2'd2);
        end
        cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        chk("bp_drained", y_valid, 1'b0);

        // Simultaneous pop and load
        cycle(4'b0001, 4'd3, 4'd0, 4'd0, 4'd0, 1'b1);
        cycle(4'b1000, 4'd0, 4'd0, 4'd0, 4'd9, 1'b1);
        chk("pl_gnt", gnt, 4'b1000);
        cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        chk("pl_y", y, 4'd9);
        chk("pl_src", y_src, 2'd3);
        chk("pl_valid", y_valid, 1'b1);
        cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Asynchronous reset with an unconsumed item
        cycle(4'b0001, 4'd5, 4'd0, 4'd0, 4'd0, 1'b1);
        cycle(4'b1010, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", y_valid, 1'b0);
        chk("arst_y", y, '0);
        chk("arst_src", y_src, 2'd0);
        chk("arst_gnt", gnt, 4'b0000);
        m_valid = 1'b0;
        m_ptr   = 3;
        exp_q.delete();
        cycle(4'b1010, 4'd0, 4'd6, 4'd0, 4'd8, 1'b1);
        chk("arst_first_gnt", gnt, 4'b0010);
        cycle(4'b1000, 4'd0, 4'd0, 4'd0, 4'd8, 1'b1);
        chk("arst_second_gnt", gnt, 4'b1000);
        cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Randomized traffic; requesters hold req/data until granted
        for (int i = 0; i < 4; i++) begin
            pend[i]  = 1'b0;
            pdat[i]  = '0;
            waitc[i] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i]  = 1'b1;
                    pdat[i]  = W'($urandom);
                    waitc[i] = 0;
                end
            end
            r = {pend[3], pend[2], pend[1], pend[0]};
            cycle(r, pdat[0], pdat[1], pdat[2], pdat[3], $urandom_range(0, 3) != 0);
            if (last_load) begin
                for (int i = 0; i < 4; i++) begin
                    if (pend[i]) waitc[i]++;
                end
                chk("starvation_bound", waitc[last_win] <= 4, 1'b1);
                pend[last_win] = 1'b0;
            end
        end

        for (int n = 0; n < 3; n++) begin
            cycle(4'b0000, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        end
        chk("sb_leftover", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_mux_arb_4.md
RR_MUX_ARB_4 -- requirements
Module: rr_mux_arb_4

Interface
REQ-001 SHALL have parameter W, default 4, meaning data width per requester and of the output.
REQ-002 SHALL have port clk  input  1  meaning single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  meaning reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  meaning request from requester i on bit i; requester holds req[i] and d_i stable until granted.
REQ-005 SHALL have ports d0, d1, d2, d3  input  W each  meaning payload of requesters 0..3.
REQ-006 SHALL have port gnt  output  4  meaning combinational one-hot grant; gnt[i]=1 means d_i is captured at this edge.
REQ-007 SHALL have port y  output  W  meaning registered selected payload.
REQ-008 SHALL have port y_valid  output  1  meaning y holds an unconsumed item.
REQ-009 SHALL have port y_ready  input  1  meaning consumer accepts y on an edge where y_valid=1 and y_ready=1.
REQ-010 SHALL have port y_src  output  2  meaning index of the requester whose payload is in y.

Function
REQ-011 SHALL have two states: EMPTY (y_valid=0) and FULL (y_valid=1).
REQ-012 SHALL compute load = (|req) & (~y_valid | y_ready).
REQ-013 SHALL assert exactly one gnt bit when load=1, and gnt=4'b0000 otherwise.
REQ-014 SHALL pick the winner by round-robin: search order ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the index of the last grant.
REQ-015 SHALL, on a load edge, register y<=d_winner, y_src<=winner, y_valid<=1 and ptr<=winner.
REQ-016 SHALL, on an edge with y_valid=1, y_ready=1 and load=0, set y_valid<=0 and hold y and y_src.
REQ-017 SHALL hold y, y_src and y_valid unchanged while y_valid=1 and y_ready=0, regardless of req.
REQ-018 SHALL, in FULL with y_ready=1 and |req=1, pop and load in the same edge, giving one item per cycle.
REQ-019 SHALL have a latency of 1 cycle: a request granted at edge t makes y valid in the cycle after edge t.
REQ-020 SHALL keep ptr unchanged when no grant occurs.
REQ-021 SHALL guarantee no starvation: a continuously held req[i] is granted within 4 load events.
REQ-022 SHALL wrap ptr from 3 to 0, so the search after a grant to 3 starts at 0.
REQ-023 SHALL ignore y_ready while y_valid=0; y_ready alone never changes state.
REQ-024 SHALL pass y through unmodified from d_winner at full width W, with no arithmetic.

Reset
REQ-025 SHALL, while rst_n=0, force y_valid=0, y='0, y_src=0, and ptr=3 so that requester 0 has first priority; gnt is then 0 because load is blocked.
REQ-026 SHALL apply reset asynchronously at any time, including in FULL with an unconsumed item; that item is discarded and no gnt is issued during reset.
REQ-027 SHALL make the first edge after rst_n rises behave as EMPTY with ptr=3.

Verification
REQ-028 SHALL cover: after reset, req=4'b1111, d={a,b,c,d}, y_ready=1 held -> gnt sequence 0001,0010,0100,1000,0001 and y sequence a,b,c,d,a, one per cycle, with y_valid=1 continuously.
REQ-029 SHALL cover backpressure: req=4'b0100, d2=7, y_ready=0 -> gnt=0100 once, y=7, y_src=2, y_valid stays 1 and gnt stays 0 for 5 cycles; then y_ready=1 with req=0 -> y_valid=0 next cycle.
REQ-030 SHALL cover rotation: ptr=1 (last grant 1), req=4'b0011 -> gnt=0001 (search order 2,3,0,1); next edge with req=4'b0010 -> gnt=0010.
REQ-031 SHALL cover simultaneous pop and load: FULL with y=3, y_ready=1, req=4'b1000, d3=9 -> gnt=1000 in the same cycle, y=9 and y_src=3 next cycle, with no y_valid gap.
REQ-032 SHALL cover reset mid-operation: FULL with y=5; rst_n=0 asynchronously between edges -> y_valid=0 and y=0 immediately; after release with req=4'b1010 -> first gnt=0010.
REQ-033 SHALL cover idle: req=0 for 10 cycles after reset -> gnt=0 and y_valid=0 throughout, with ptr unchanged as shown by the next grant order.
